// File: rtl/portal_mux_pkg.sv
// Shared constants and helpers for the portal multiplexer and its channel FIFOs.
package portal_mux_pkg;

    localparam logic [31:0] INTR_NONE = 32'd0;
    localparam int unsigned ERRCNT_W  = 16;
    localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = 16'hFFFF;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/portal_fifo.sv
// Synchronous per-channel FIFO with a registered head; no fall-through when empty.
module portal_fifo
    import portal_mux_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         enq,
    input  logic         deq,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full_n,
    output logic         empty_n
);

    localparam int unsigned     AW       = clog2(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]     CNT_FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_enq;
    logic          do_deq;

    always_comb begin
        empty_n  = (count_q != '0);
        full_n   = (count_q != CNT_FULL);
        // a full FIFO still accepts an enqueue paired with a real dequeue
        do_deq   = deq && empty_n;
        do_enq   = enq && (full_n || do_deq);

        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (do_enq) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_deq) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_enq, do_deq})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        dout = mem_q[rd_ptr_q];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/portal_mux.sv
// Host-to-DUT portal multiplexer: steered request/indication FIFOs plus interrupt channel numbers.
// Defining PORTAL_MUX_ERRCNT_EN adds the saturating rejected-operation counter on err_count.
module portal_mux
    import portal_mux_pkg::*;
#(
    parameter int unsigned  W      = 32,
    parameter int unsigned  N_REQ  = 3,
    parameter int unsigned  N_IND  = 2,
    parameter int unsigned  DEPTH  = 8,
    localparam int unsigned SELW_R = clog2(N_REQ + 1),
    localparam int unsigned SELW_I = clog2(N_IND + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [SELW_R-1:0]    req_sel,
    input  logic [W-1:0]         req_enq_v,
    input  logic                 req_enq_en,
    output logic                 req_enq_rdy,
    input  logic [SELW_I-1:0]    ind_sel,
    input  logic                 ind_deq_en,
    output logic [W-1:0]         ind_data,
    output logic                 ind_rdy,
    output logic [31:0]          req_intr_channel,
    output logic [31:0]          ind_intr_channel,
    output logic [N_REQ*W-1:0]   pipe_first,
    output logic [N_REQ-1:0]     pipe_valid,
    input  logic [N_REQ-1:0]     pipe_deq,
    input  logic [N_IND*W-1:0]   dut_ind_v,
    input  logic [N_IND-1:0]     dut_ind_en,
    output logic [N_IND-1:0]     dut_ind_rdy,
    output logic [ERRCNT_W-1:0]  err_count
);

    logic [N_REQ-1:0]  req_enq_vec;
    logic [N_REQ-1:0]  req_full_n;
    logic [N_REQ-1:0]  req_empty_n;
    logic [N_IND-1:0]  ind_deq_vec;
    logic [N_IND-1:0]  ind_full_n;
    logic [N_IND-1:0]  ind_empty_n;
    logic [W-1:0]      ind_dout [N_IND];

    logic [31:0]       req_intr_q, req_intr_d;
    logic [31:0]       ind_intr_q, ind_intr_d;
    logic [SELW_I-1:0] rr_q, rr_d;

    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        portal_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .CLK     (CLK),
            .RST     (RST),
            .enq     (req_enq_vec[g]),
            .deq     (pipe_deq[g]),
            .din     (req_enq_v),
            .dout    (pipe_first[g*W +: W]),
            .full_n  (req_full_n[g]),
            .empty_n (req_empty_n[g])
        );
    end

    for (genvar g = 0; g < N_IND; g++) begin : g_ind
        portal_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .CLK     (CLK),
            .RST     (RST),
            .enq     (dut_ind_en[g]),
            .deq     (ind_deq_vec[g]),
            .din     (dut_ind_v[g*W +: W]),
            .dout    (ind_dout[g]),
            .full_n  (ind_full_n[g]),
            .empty_n (ind_empty_n[g])
        );
    end

    assign pipe_valid  = req_empty_n;
    assign dut_ind_rdy = ind_full_n;

    // Out-of-range selects match no channel, so strobes are dropped and outputs stay zero.
    always_comb begin
        req_enq_vec = '0;
        req_enq_rdy = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_sel == SELW_R'(i)) begin
                req_enq_vec[i] = req_enq_en;
                req_enq_rdy    = req_full_n[i];
            end
        end

        ind_deq_vec = '0;
        ind_rdy     = 1'b0;
        ind_data    = '0;
        for (int unsigned i = 0; i < N_IND; i++) begin
            if (ind_sel == SELW_I'(i)) begin
                ind_deq_vec[i] = ind_deq_en;
                ind_rdy        = ind_empty_n[i];
                ind_data       = ind_dout[i];
            end
        end
    end

    always_comb begin
        int unsigned idx;
        logic        found;

        req_intr_d = INTR_NONE;
        for (int unsigned i = N_REQ; i > 0; i--) begin
            if (!req_full_n[i-1]) begin
                req_intr_d = 32'(i);
            end
        end

        ind_intr_d = INTR_NONE;
        found      = 1'b0;
        idx        = 0;
        for (int unsigned k = 0; k < N_IND; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= N_IND) begin
                idx = idx - N_IND;
            end
            if (!found && ind_empty_n[idx]) begin
                found      = 1'b1;
                ind_intr_d = 32'(idx + 1);
            end
        end

        // Servicing the advertised channel hands priority to the next one.
        rr_d = rr_q;
        for (int unsigned c = 0; c < N_IND; c++) begin
            if (ind_deq_vec[c] && ind_empty_n[c] && (ind_intr_q == 32'(c + 1))) begin
                rr_d = (c + 1 == N_IND) ? '0 : SELW_I'(c + 1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            req_intr_q <= INTR_NONE;
            ind_intr_q <= INTR_NONE;
            rr_q       <= '0;
        end else begin
            req_intr_q <= req_intr_d;
            ind_intr_q <= ind_intr_d;
            rr_q       <= rr_d;
        end
    end

    assign req_intr_channel = req_intr_q;
    assign ind_intr_channel = ind_intr_q;

`ifdef PORTAL_MUX_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_q, err_d;
    logic [ERRCNT_W:0]   err_sum;
    logic                req_accept;
    logic                ind_accept;
    logic                req_rej;
    logic                ind_rej;

    always_comb begin
        req_accept = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_sel == SELW_R'(i)) begin
                req_accept = req_full_n[i] || (pipe_deq[i] && req_empty_n[i]);
            end
        end
        ind_accept = 1'b0;
        for (int unsigned i = 0; i < N_IND; i++) begin
            if (ind_sel == SELW_I'(i)) begin
                ind_accept = ind_empty_n[i];
            end
        end
        req_rej = req_enq_en && !req_accept;
        ind_rej = ind_deq_en && !ind_accept;
        err_sum = {1'b0, err_q} + (ERRCNT_W + 1)'(req_rej) + (ERRCNT_W + 1)'(ind_rej);
        err_d   = (err_sum > {1'b0, ERRCNT_MAX}) ? ERRCNT_MAX : err_sum[ERRCNT_W-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_portal_mux.sv
// Randomised self-checking bench for portal_mux against a queue-based channel model.
module tb_portal_mux;

    localparam int unsigned W     = 32;
    localparam int unsigned N_REQ = 3;
    localparam int unsigned N_IND = 2;
    localparam int unsigned DEPTH = 8;

`ifdef PORTAL_MUX_ERRCNT_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic               CLK = 1'b0;
    logic               RST;
    logic [1:0]         req_sel;
    logic [W-1:0]       req_enq_v;
    logic               req_enq_en;
    logic               req_enq_rdy;
    logic [1:0]         ind_sel;
    logic               ind_deq_en;
    logic [W-1:0]       ind_data;
    logic               ind_rdy;
    logic [31:0]        req_intr_channel;
    logic [31:0]        ind_intr_channel;
    logic [N_REQ*W-1:0] pipe_first;
    logic [N_REQ-1:0]   pipe_valid;
    logic [N_REQ-1:0]   pipe_deq;
    logic [N_IND*W-1:0] dut_ind_v;
    logic [N_IND-1:0]   dut_ind_en;
    logic [N_IND-1:0]   dut_ind_rdy;
    logic [15:0]        err_count;

    always #5 CLK = ~CLK;

    portal_mux #(
        .W     (W),
        .N_REQ (N_REQ),
        .N_IND (N_IND),
        .DEPTH (DEPTH)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .req_sel          (req_sel),
        .req_enq_v        (req_enq_v),
        .req_enq_en       (req_enq_en),
        .req_enq_rdy      (req_enq_rdy),
        .ind_sel          (ind_sel),
        .ind_deq_en       (ind_deq_en),
        .ind_data         (ind_data),
        .ind_rdy          (ind_rdy),
        .req_intr_channel (req_intr_channel),
        .ind_intr_channel (ind_intr_channel),
        .pipe_first       (pipe_first),
        .pipe_valid       (pipe_valid),
        .pipe_deq         (pipe_deq),
        .dut_ind_v        (dut_ind_v),
        .dut_ind_en       (dut_ind_en),
        .dut_ind_rdy      (dut_ind_rdy),
        .err_count        (err_count)
    );

    // Reference model: one queue per channel plus the advertised interrupt values.
    logic [W-1:0] rq [N_REQ][$];
    logic [W-1:0] iq [N_IND][$];
    int rr;
    int exp_req_intr;
    int exp_ind_intr;
    int exp_err;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_REQ; i++) rq[i].delete();
        for (int i = 0; i < N_IND; i++) iq[i].delete();
        rr           = 0;
        exp_req_intr = 0;
        exp_ind_intr = 0;
        exp_err      = 0;
    endtask

    task automatic check_outputs();
        logic [N_REQ-1:0] v;
        logic [N_IND-1:0] r;
        for (int i = 0; i < N_REQ; i++) v[i] = (rq[i].size() != 0);
        check("pipe_valid", pipe_valid, v);
        for (int i = 0; i < N_REQ; i++)
            if (rq[i].size() != 0) check("pipe_first", pipe_first[i*W +: W], rq[i][0]);
        for (int i = 0; i < N_IND; i++) r[i] = (iq[i].size() < DEPTH);
        check("dut_ind_rdy", dut_ind_rdy, r);
        if (req_sel < N_REQ) check("req_enq_rdy", req_enq_rdy, rq[req_sel].size() < DEPTH);
        else                 check("req_enq_rdy", req_enq_rdy, 0);
        if (ind_sel < N_IND) begin
            check("ind_rdy", ind_rdy, iq[ind_sel].size() != 0);
            if (iq[ind_sel].size() != 0) check("ind_data", ind_data, iq[ind_sel][0]);
        end else begin
            check("ind_rdy", ind_rdy, 0);
            check("ind_data", ind_data, 0);
        end
        check("req_intr", req_intr_channel, exp_req_intr);
        check("ind_intr", ind_intr_channel, exp_ind_intr);
        check("err_count", err_count, ERR_ON ? exp_err : 0);
    endtask

    // Applies the channel rules to the inputs currently driven, as of the coming edge.
    task automatic model_update();
        int  nreq, nind, rej, hc, c, sel;
        bit  deq_r [N_REQ];
        bit  req_acc;
        bit  ind_acc [N_IND];
        if (RST) begin
            model_reset();
            return;
        end
        nreq = 0;
        for (int i = N_REQ - 1; i >= 0; i--) if (rq[i].size() == DEPTH) nreq = i + 1;
        nind = 0;
        for (int k = 0; k < N_IND; k++) begin
            c = (rr + k) % N_IND;
            if (nind == 0 && iq[c].size() != 0) nind = c + 1;
        end
        rej = 0;
        for (int i = 0; i < N_REQ; i++) deq_r[i] = pipe_deq[i] && (rq[i].size() != 0);
        sel     = int'(req_sel);
        req_acc = 1'b0;
        if (req_enq_en) begin
            if (sel < N_REQ && (rq[sel].size() < DEPTH || deq_r[sel])) req_acc = 1'b1;
            else rej++;
        end
        for (int i = 0; i < N_REQ; i++) if (deq_r[i]) void'(rq[i].pop_front());
        if (req_acc) rq[sel].push_back(req_enq_v);

        hc = -1;
        if (ind_deq_en) begin
            if (ind_sel < N_IND && iq[ind_sel].size() != 0) hc = int'(ind_sel);
            else rej++;
        end
        if (hc >= 0 && exp_ind_intr == hc + 1) rr = (hc + 1) % N_IND;
        for (int i = 0; i < N_IND; i++)
            ind_acc[i] = dut_ind_en[i] && (iq[i].size() < DEPTH || hc == i);
        if (hc >= 0) void'(iq[hc].pop_front());
        for (int i = 0; i < N_IND; i++) if (ind_acc[i]) iq[i].push_back(dut_ind_v[i*W +: W]);

        exp_err      = (exp_err + rej > 65535) ? 65535 : exp_err + rej;
        exp_req_intr = nreq;
        exp_ind_intr = nind;
    endtask

    // Entered just after a falling edge with inputs driven; returns at the next falling edge.
    task automatic tick();
        #1;
        check_outputs();
        model_update();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle();
        RST        = 1'b0;
        req_enq_en = 1'b0;
        ind_deq_en = 1'b0;
        pipe_deq   = '0;
        dut_ind_en = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] sent_q [$];
        int got_n, k, mode, en_p, deq_p;

        idle();
        RST       = 1'b1;
        req_sel   = '0;
        ind_sel   = '0;
        req_enq_v = '0;
        dut_ind_v = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        #1;
        check("rst_pipe_valid", pipe_valid, 3'b000);
        check("rst_dut_ind_rdy", dut_ind_rdy, 2'b11);
        check("rst_ind_rdy", ind_rdy, 1'b0);
        check("rst_req_enq_rdy", req_enq_rdy, 1'b1);
        check("rst_req_intr", req_intr_channel, 32'd0);
        check("rst_ind_intr", ind_intr_channel, 32'd0);
        check("rst_err", err_count, 16'd0);

        // Single request word through channel 1.
        req_sel = 2'd1; req_enq_v = 32'hA5A5_0001; req_enq_en = 1'b1;
        tick(); idle();
        check("tp1_valid", pipe_valid, 3'b010);
        check("tp1_first", pipe_first[63:32], 32'hA5A5_0001);
        pipe_deq = 3'b010;
        tick(); idle();
        check("tp1_drain", pipe_valid, 3'b000);

        // Fill channel 0, overflow strobe, full-with-dequeue.
        req_sel = 2'd0;
        for (int i = 0; i < 8; i++) begin
            req_enq_v = $urandom; req_enq_en = 1'b1;
            tick();
        end
        idle(); #1;
        check("tp2_rdy_full", req_enq_rdy, 1'b0);
        tick();
        check("tp2_req_intr", req_intr_channel, 32'd1);
        req_enq_v = 32'hDEAD_0009; req_enq_en = 1'b1;
        tick(); idle();
        check("tp2_err", err_count, ERR_ON ? 16'd1 : 16'd0);
        pipe_deq = 3'b001; req_enq_v = 32'hBEEF_000A; req_enq_en = 1'b1;
        tick(); idle(); #1;
        check("tp2_still_full", req_enq_rdy, 1'b0);
        check("tp2_still_intr", req_intr_channel, 32'd1);
        pipe_deq = 3'b001;
        repeat (8) tick();
        idle(); tick();

        // Indication round robin.
        dut_ind_v = {32'h22, 32'h11}; dut_ind_en = 2'b11;
        tick(); idle(); tick();
        check("tp3_intr_a", ind_intr_channel, 32'd1);
        ind_sel = 2'd0; ind_deq_en = 1'b1;
        tick(); idle(); tick();
        check("tp3_intr_b", ind_intr_channel, 32'd2);
        ind_sel = 2'd1; #1;
        check("tp3_data", ind_data, 32'h22);
        ind_deq_en = 1'b1;
        tick(); idle(); tick();
        check("tp3_intr_c", ind_intr_channel, 32'd0);

        // Out-of-range selects.
        req_sel = 2'd3; req_enq_en = 1'b1; #1;
        check("tp4_req_rdy", req_enq_rdy, 1'b0);
        tick(); idle();
        ind_sel = 2'd2; ind_deq_en = 1'b1; #1;
        check("tp4_ind_rdy", ind_rdy, 1'b0);
        check("tp4_ind_data", ind_data, 32'd0);
        tick(); idle();
        check("tp4_err", err_count, ERR_ON ? 16'd3 : 16'd0);
        check("tp4_nochange", pipe_valid, 3'b000);

        // 20 words through channel 2 with interleaved traffic across pointer wrap.
        req_sel = 2'd2; got_n = 0; k = 0;
        while (got_n < 20 && k < 80) begin
            req_enq_en = (sent_q.size() < 20) && (k % 3 != 2);
            req_enq_v  = 32'hC000_0000 + 32'(sent_q.size() * 7);
            pipe_deq   = (k >= 3) ? 3'b100 : 3'b000;
            #1;
            if (pipe_deq[2] && pipe_valid[2]) begin
                check("tp5_order", pipe_first[95:64], sent_q[got_n]);
                got_n++;
            end
            if (req_enq_en) sent_q.push_back(req_enq_v);
            tick();
            k++;
        end
        idle();
        check("tp5_count", got_n, 20);

        // Reset with queued indications and a full request channel.
        dut_ind_en = 2'b10;
        for (int i = 0; i < 5; i++) begin
            dut_ind_v = {$urandom, $urandom};
            tick();
        end
        idle();
        req_sel = 2'd1;
        for (int i = 0; i < 8; i++) begin
            req_enq_v = $urandom; req_enq_en = 1'b1;
            tick();
        end
        idle(); tick();
        check("tp6_pre_intr", req_intr_channel, 32'd2);
        RST = 1'b1;
        tick(); idle();
        ind_sel = 2'd1; #1;
        check("tp6_ind_rdy", ind_rdy, 1'b0);
        check("tp6_dut_rdy", dut_ind_rdy, 2'b11);
        check("tp6_req_intr", req_intr_channel, 32'd0);
        check("tp6_ind_intr", ind_intr_channel, 32'd0);
        check("tp6_err", err_count, 16'd0);
        check("tp6_valid", pipe_valid, 3'b000);

        // Random traffic in fill, drain and balanced phases.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            mode  = (cyc / 200) % 3;
            en_p  = (mode == 0) ? 80 : (mode == 1) ? 20 : 50;
            deq_p = 100 - en_p;
            RST        = ($urandom_range(0, 599) == 0);
            req_sel    = 2'($urandom_range(0, 3));
            ind_sel    = 2'($urandom_range(0, 3));
            req_enq_v  = $urandom;
            req_enq_en = ($urandom_range(0, 99) < en_p);
            ind_deq_en = ($urandom_range(0, 99) < deq_p);
            for (int i = 0; i < N_REQ; i++) pipe_deq[i] = ($urandom_range(0, 99) < deq_p);
            for (int i = 0; i < N_IND; i++) dut_ind_en[i] = ($urandom_range(0, 99) < en_p);
            dut_ind_v  = {$urandom, $urandom};
            tick();
        end
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
